// File: rtl/ac_button_conditioner_pkg.sv
// Shared types and default timing constants for the
// air-conditioner setpoint front end.
package ac_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      REPEAT  = 2'd2,
      LOCKOUT = 2'd3
   } chan_state_t;

   localparam int DEBOUNCE_CYCLES = 4;
   localparam int REPEAT_DELAY    = 8;
   localparam int REPEAT_PERIOD   = 4;
   localparam int CNT_W           = 4;

endpackage

// File: rtl/ac_button_conditioner_btn_channel.sv
// One button channel: synchroniser, debounce and
// press / auto-repeat FSM with a lockout state.
module btn_channel
   import ac_pkg::*;
#(
   parameter int DEB_CYC = DEBOUNCE_CYCLES,
   parameter int RPT_DLY = REPEAT_DELAY,
   parameter int RPT_PER = REPEAT_PERIOD,
   parameter int CW      = CNT_W
) (
   input  logic clk_2,
   input  logic reset_n,
   input  logic raw,
   input  logic lock_req,
   output logic held,
   output logic pulse,
   output logic locked
);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_held;
   logic          r_pulse;
   logic [CW-1:0] r_db_cnt;
   logic [CW-1:0] r_cnt;
   chan_state_t   r_state;

   chan_state_t   w_state_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic [CW-1:0] w_cnt_inc;
   logic          w_pulse_nxt;
   logic          w_dly_done;
   logic          w_per_done;

   assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
   assign w_dly_done = (r_cnt == CW'(RPT_DLY - 1));
   assign w_per_done = (r_cnt == CW'(RPT_PER - 1));

   // Two-flop synchroniser for the asynchronous raw input
   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= raw;
         r_sync2 <= r_sync1;
      end
   end

   // Debounce: flip the level after a full run of disagreeing samples
   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         r_held   <= 1'b0;
         r_db_cnt <= '0;
      end else if (r_sync2 == r_held) begin
         r_db_cnt <= '0;
      end else if (r_db_cnt == CW'(DEB_CYC - 1)) begin
         r_held   <= ~r_held;
         r_db_cnt <= '0;
      end else begin
         r_db_cnt <= r_db_cnt + 1'b1;
      end
   end

   // FSM state, repeat counter and registered pulse
   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_pulse <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_pulse <= w_pulse_nxt;
      end
   end

   // Next state; a lock request overrides every state
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (lock_req) begin
         w_state_nxt = LOCKOUT;
         w_cnt_nxt   = '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (r_held) begin
                  w_state_nxt = WAIT;
                  w_cnt_nxt   = '0;
               end
            end
            WAIT: begin
               if (!r_held) begin
                  w_state_nxt = IDLE;
                  w_cnt_nxt   = '0;
               end else if (w_dly_done) begin
                  w_state_nxt = REPEAT;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = w_cnt_inc;
               end
            end
            REPEAT: begin
               if (!r_held) begin
                  w_state_nxt = IDLE;
                  w_cnt_nxt   = '0;
               end else if (w_per_done) begin
                  w_cnt_nxt = '0;
               end else begin
                  w_cnt_nxt = w_cnt_inc;
               end
            end
            LOCKOUT: begin
               if (!r_held) begin
                  w_state_nxt = IDLE;
                  w_cnt_nxt   = '0;
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Pulse decision for the coming cycle
   always_comb begin
      w_pulse_nxt = 1'b0;
      if (!lock_req) begin
         unique case (r_state)
            IDLE:    w_pulse_nxt = r_held;
            WAIT:    w_pulse_nxt = r_held & w_dly_done;
            REPEAT:  w_pulse_nxt = r_held & w_per_done;
            default: w_pulse_nxt = 1'b0;
         endcase
      end
   end

   assign held   = r_held;
   assign pulse  = r_pulse;
   assign locked = (r_state == LOCKOUT);

endmodule

// File: rtl/ac_button_conditioner.sv
// UP/DOWN button conditioner: two debounced channels
// with auto-repeat and a both-pressed lockout.
module ac_button_conditioner
   import ac_pkg::*;
#(
   parameter int DEB_CYC = DEBOUNCE_CYCLES,
   parameter int RPT_DLY = REPEAT_DELAY,
   parameter int RPT_PER = REPEAT_PERIOD,
   parameter int CW      = CNT_W
) (
   input  logic clk_2,
   input  logic reset_n,
   input  logic btn_up_raw,
   input  logic btn_down_raw,
   output logic up_pulse,
   output logic down_pulse,
   output logic up_held,
   output logic down_held,
   output logic conflict
);

   logic w_lock_req;
   logic w_up_held;
   logic w_dn_held;
   logic w_up_pulse;
   logic w_dn_pulse;
   logic w_up_locked;
   logic w_dn_locked;

   assign w_lock_req = w_up_held & w_dn_held;

   btn_channel #(
      .DEB_CYC (DEB_CYC),
      .RPT_DLY (RPT_DLY),
      .RPT_PER (RPT_PER),
      .CW      (CW)
   ) u_up (
      .clk_2    (clk_2),
      .reset_n  (reset_n),
      .raw      (btn_up_raw),
      .lock_req (w_lock_req),
      .held     (w_up_held),
      .pulse    (w_up_pulse),
      .locked   (w_up_locked)
   );

   btn_channel #(
      .DEB_CYC (DEB_CYC),
      .RPT_DLY (RPT_DLY),
      .RPT_PER (RPT_PER),
      .CW      (CW)
   ) u_dn (
      .clk_2    (clk_2),
      .reset_n  (reset_n),
      .raw      (btn_down_raw),
      .lock_req (w_lock_req),
      .held     (w_dn_held),
      .pulse    (w_dn_pulse),
      .locked   (w_dn_locked)
   );

   // Kill pulses in the very cycle both levels are high
   always_comb begin
      up_pulse   = w_up_pulse & ~w_lock_req;
      down_pulse = w_dn_pulse & ~w_lock_req;
      up_held    = w_up_held;
      down_held  = w_dn_held;
      conflict   = w_up_locked | w_dn_locked;
   end

endmodule

// File: tb/tb_ac_button_conditioner.sv
// Scoreboard bench for ac_button_conditioner against
// a rule-level reference model.
module tb_ac_button_conditioner;

   localparam int DB = 4;
   localparam int RD = 8;
   localparam int RP = 4;

   logic clk;
   logic reset_n;
   logic btn_up_raw;
   logic btn_down_raw;
   logic up_pulse;
   logic down_pulse;
   logic up_held;
   logic down_held;
   logic conflict;

   int n_tests = 0;
   int n_fail  = 0;
   int n_cyc   = 0;
   int n_up    = 0;
   int n_dn    = 0;
   int n_uh    = 0;
   int n_cf    = 0;
   int n_any   = 0;

   logic [4:0] sb[$];

   bit hist_u[$];
   bit hist_d[$];
   bit m_held[2];
   bit m_lock[2];
   bit m_act[2];
   bit m_pls[2];
   int m_age[2];

   ac_button_conditioner dut (
      .clk_2        (clk),
      .reset_n      (reset_n),
      .btn_up_raw   (btn_up_raw),
      .btn_down_raw (btn_down_raw),
      .up_pulse     (up_pulse),
      .down_pulse   (down_pulse),
      .up_held      (up_held),
      .down_held    (down_held),
      .conflict     (conflict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit samp(input int c, input int j);
      if (j < 0) return 1'b0;
      return (c == 0) ? hist_u[j] : hist_d[j];
   endfunction

   // pulse due at this many cycles after the first pulse
   function automatic bit due(input int age);
      if (age == RD) return 1'b1;
      if (age > RD && ((age - RD) % RP) == 0) return 1'b1;
      return 1'b0;
   endfunction

   // Reference model: evaluated once per rising edge
   always @(posedge clk) begin
      bit lk;
      bit all;
      bit both;
      int n;
      logic [4:0] e;
      if (!reset_n) begin
         hist_u.delete();
         hist_d.delete();
         for (int c = 0; c < 2; c++) begin
            m_held[c] = 0;
            m_lock[c] = 0;
            m_act[c]  = 0;
            m_pls[c]  = 0;
            m_age[c]  = 0;
         end
         e = '0;
      end else begin
         hist_u.push_back(btn_up_raw);
         hist_d.push_back(btn_down_raw);
         lk = m_held[0] && m_held[1];
         for (int c = 0; c < 2; c++) begin
            m_pls[c] = 0;
            if (m_lock[c]) begin
               if (!m_held[c]) m_lock[c] = 0;
            end else if (lk) begin
               m_lock[c] = 1;
               m_act[c]  = 0;
            end else if (!m_act[c]) begin
               if (m_held[c]) begin
                  m_act[c] = 1;
                  m_age[c] = 0;
                  m_pls[c] = 1;
               end
            end else if (!m_held[c]) begin
               m_act[c] = 0;
            end else begin
               m_age[c] = m_age[c] + 1;
               m_pls[c] = due(m_age[c]);
            end
         end
         n = hist_u.size() - 1;
         for (int c = 0; c < 2; c++) begin
            all = 1;
            for (int j = n - 1 - DB; j <= n - 2; j++)
               if (samp(c, j) == m_held[c]) all = 0;
            if (all) m_held[c] = !m_held[c];
         end
         both = m_held[0] && m_held[1];
         e = {m_pls[0] && !both, m_pls[1] && !both,
              m_held[0], m_held[1], m_lock[0] || m_lock[1]};
      end
      sb.push_back(e);
   end

   // Monitor: pops one expectation per cycle
   always @(negedge clk) begin
      logic [4:0] got;
      logic [4:0] want;
      got = {up_pulse, down_pulse, up_held, down_held, conflict};
      n_cyc++;
      n_tests++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL sb_empty cyc=%0d got=%b", n_cyc, got);
      end else begin
         want = sb.pop_front();
         if (got !== want) begin
            n_fail++;
            $display("FAIL outputs cyc=%0d got=%b want=%b (up,dn,uh,dh,cf)",
                     n_cyc, got, want);
         end
      end
      n_tests++;
      if (up_pulse === 1'b1 && down_pulse === 1'b1) begin
         n_fail++;
         $display("FAIL both_pulses cyc=%0d got=11 want=not both", n_cyc);
      end
      if (up_pulse)   n_up++;
      if (down_pulse) n_dn++;
      if (up_held)    n_uh++;
      if (conflict)   n_cf++;
      if (got != '0)  n_any++;
   end

   task automatic chk(input string name, input int got, input int want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   task automatic step(input bit u, input bit d);
      @(negedge clk);
      #1;
      btn_up_raw   = u;
      btn_down_raw = d;
   endtask

   task automatic hold(input bit u, input bit d, input int n);
      repeat (n) step(u, d);
   endtask

   task automatic clr_cnt();
      n_up  = 0;
      n_dn  = 0;
      n_uh  = 0;
      n_cf  = 0;
      n_any = 0;
   endtask

   initial begin
      bit u;
      bit d;
      int dur;
      reset_n      = 1'b0;
      btn_up_raw   = 1'b0;
      btn_down_raw = 1'b0;

      // reset then idle
      clr_cnt();
      hold(0, 0, 3);
      reset_n = 1'b1;
      hold(0, 0, 20);
      chk("idle_quiet", n_any, 0);

      // single short press
      clr_cnt();
      hold(1, 0, 8);
      hold(0, 0, 12);
      chk("press_one_pulse", n_up, 1);
      chk("press_no_down", n_dn, 0);
      chk("press_held_seen", (n_uh > 0) ? 1 : 0, 1);

      // bounce shorter than the debounce window
      clr_cnt();
      for (int i = 0; i < 5; i++) begin
         hold(1, 0, 2);
         hold(0, 0, 2);
      end
      hold(0, 0, 10);
      chk("bounce_held", n_uh, 0);
      chk("bounce_pulse", n_up, 0);

      // long DOWN hold with auto-repeat
      clr_cnt();
      hold(0, 1, 30);
      hold(0, 0, 12);
      chk("repeat_some", (n_dn >= 4) ? 1 : 0, 1);
      chk("repeat_no_up", n_up, 0);

      // UP held, DOWN joins, then DOWN released
      clr_cnt();
      hold(1, 0, 10);
      chk("conf_first_up", n_up, 1);
      hold(1, 1, 20);
      chk("conf_flag", (n_cf > 0) ? 1 : 0, 1);
      clr_cnt();
      hold(1, 0, 20);
      chk("conf_up_locked", n_up, 0);
      hold(0, 0, 12);
      clr_cnt();
      hold(1, 0, 10);
      chk("conf_repress", n_up, 1);
      hold(0, 0, 12);

      // async reset during auto-repeat
      hold(1, 0, 25);
      @(negedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      chk("async_reset_out",
          int'({up_pulse, down_pulse, up_held, down_held, conflict}), 0);
      hold(1, 0, 2);
      clr_cnt();
      reset_n = 1'b1;
      hold(1, 0, 10);
      chk("post_reset_pulse", n_up, 1);
      hold(0, 0, 12);

      // randomized traffic
      for (int i = 0; i < 70; i++) begin
         u   = 1'($urandom_range(0, 1));
         d   = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
         dur = $urandom_range(1, 35);
         hold(u, d, dur);
         if ($urandom_range(0, 24) == 0) begin
            reset_n = 1'b0;
            hold(u, d, 2);
            reset_n = 1'b1;
         end
      end
      hold(0, 0, 15);

      @(negedge clk);
      #2;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
